branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor, successor to the static-prediction control-hazard logic.
- Holds a pattern history table (PHT) of saturating counters, read combinationally in IF to produce the prediction.
- Updated when a branch resolves in EXE; in the same cycle it raises flush and supplies the rollback PC on a mispredict.
- Optional gshare mode XORs a global history register (GHR) into the PHT index; 32-bit statistics counters support performance evaluation.

Parameters:
- IDX_W, 4, PHT index width; table holds 2**IDX_W entries (legal 1..10).
- CTR_W, 2, counter width per entry (legal 1..4).
- INIT_CTR, 2, reset value of every counter; must be < 2**CTR_W. Default is weakly taken.
- GSHARE, 0, 0 = bimodal index, 1 = gshare index.

Ports:
- clk_i, input, 1, clock (rising edge).
- rst_i, input, 1, reset, asynchronous, active-low.
- pc_if, input, 32, PC of the instruction being fetched.
- predict_taken, output, 1, prediction for pc_if.
- pred_idx_if, output, IDX_W, PHT index used for pc_if; the pipeline carries it to EXE.
- branch_exe, input, 1, EXE holds a valid conditional branch.
- pred_exe, input, 1, prediction that was carried with that branch.
- idx_exe, input, IDX_W, pred_idx_if value carried with that branch.
- is_zero, input, 1, branch outcome (1 = taken).
- pc_exe, input, 32, PC of the EXE branch.
- imm_exe, input, 32, branch immediate (halfword units).
- flush, output, 1, mispredict; flushes IF/ID and ID/EX.
- pc_rollback, output, 32, corrected next PC.
- branch_cnt, output, 32, resolved branches.
- mispred_cnt, output, 32, mispredicts.

Behaviour:
- Reset (rst_i low, asynchronous, legal mid-operation):
  - All PHT entries = INIT_CTR; GHR = 0; branch_cnt = mispred_cnt = 0.
  - predict_taken = INIT_CTR[CTR_W-1] for any pc_if.
  - No update occurs on the clock edge at which reset releases while branch_exe is high.
- Index:
  - Bimodal: pc_if[IDX_W+1:2].
  - Gshare: pc_if[IDX_W+1:2] XOR GHR[IDX_W-1:0].
  - pred_idx_if outputs the computed index. pc_if[1:0] are ignored.
- Prediction: combinational; predict_taken = PHT[pred_idx_if][CTR_W-1] (counter MSB).
- Mispredict (combinational, zero latency):
  - flush = branch_exe & (pred_exe != is_zero).
  - pc_rollback = (branch_exe & is_zero) ? pc_exe + (imm_exe << 1) : pc_exe + 4, mod 2**32 with no overflow flag.
  - pc_rollback is meaningful only when flush = 1 but is always driven.
- Update, on the rising edge when branch_exe = 1:
  - PHT[idx_exe]: +1 if is_zero, saturating at 2**CTR_W-1; -1 otherwise, saturating at 0.
  - GHR <= {GHR[IDX_W-2:0], is_zero}; for IDX_W = 1 the GHR is simply is_zero. The GHR is updated non-speculatively, in EXE only.
  - branch_cnt += 1; mispred_cnt += flush. Both saturate at 0xFFFFFFFF with no wrap.
  - branch_exe = 0 changes no state.
- Simultaneous read/write of the same entry: the IF read returns the pre-update value; there is no bypass. The write is visible from the next cycle.
- The GHR shift and the PHT write use the pre-edge GHR. idx_exe is used as given and is never recomputed from pc_exe.
- CTR_W = 1: the counter is a last-outcome bit.
- The block never stalls. The hazard unit's stall has no effect here, since branch_exe must already be qualified by the pipeline.

Decomposition:
- Shared package:
  - Counter saturation helpers (inc_sat, dec_sat).
  - Constant PC_STEP = 4.
  - Rollback target function shared with the existing control-hazard logic.
- One sub-module, sat_counter_table:
  - Holds the PHT array, reset init, one combinational read port and one synchronous write port.
  - Takes IDX_W, CTR_W and INIT_CTR as parameters.
- Top level holds the GHR, index hashing, flush/rollback and statistics.

Test Plan:
- Reset with defaults: pc_if = 0x40 → predict_taken = 1, pred_idx_if = 0. branch_cnt = mispred_cnt = 0.
- Bimodal saturation:
  - Four not-taken resolutions of pc_exe = 0x40 (idx 0) with pred_exe = 1, 1, 0, 0.
  - Required: flush = 1, 1, 0, 0; entry goes 2→1→0→0; predict_taken for 0x40 = 0 after the second update.
  - A fifth not-taken resolution leaves the entry at 0.
- Rollback values:
  - pc_exe = 0x100, imm = 0x8, is_zero = 1, pred = 0 → flush = 1, pc_rollback = 0x110.
  - Same branch with is_zero = 0, pred = 1 → pc_rollback = 0x104.
  - pc_exe = 0xFFFFFFFC, not taken → pc_rollback = 0x0.
- Same-cycle read/write: pc_if = 0x40, idx_exe = 0, entry = 1, taken update → predict_taken = 0 this cycle, 1 next cycle.
- Gshare (GSHARE = 1, IDX_W = 4):
  - Resolve taken, taken, not-taken → GHR = 0b0110.
  - pc_if = 0x48 then gives pred_idx_if = 2 XOR 6 = 4.
  - Assert rst_i low mid-cycle → GHR = 0 and all counters = 2 immediately.
- Statistics: branch_cnt preloaded via force to 0xFFFFFFFF, then one branch resolves → branch_cnt stays 0xFFFFFFFF. Idle cycles with branch_exe = 0 leave both counts unchanged.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter saturation
// and the EXE rollback target that the control-hazard logic also uses.
package branch_predictor_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t PC_STEP   = 32'd4;
  localparam int  CTR_MAX_W = 4;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t inc_sat(input ctr_t ctr, input ctr_t max);
    return (ctr >= max) ? max : ctr + ctr_t'(1);
  endfunction

  function automatic ctr_t dec_sat(input ctr_t ctr);
    return (ctr == '0) ? '0 : ctr - ctr_t'(1);
  endfunction

  // Immediate is in halfword units, hence the shift.
  function automatic pc_t rollback_target(input logic branch, input logic taken,
                                          input pc_t pc, input pc_t imm);
    return (branch && taken) ? pc + (imm << 1) : pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing bus of the branch predictor: IF lookup, EXE resolution and statistics.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 4
);
  pc_t              pc_if;
  logic             predict_taken;
  logic [IDX_W-1:0] pred_idx_if;

  logic             branch_exe;
  logic             pred_exe;
  logic [IDX_W-1:0] idx_exe;
  logic             is_zero;
  pc_t              pc_exe;
  pc_t              imm_exe;

  logic             flush;
  pc_t              pc_rollback;
  pc_t              branch_cnt;
  pc_t              mispred_cnt;

  modport master (
    output pc_if, branch_exe, pred_exe, idx_exe, is_zero, pc_exe, imm_exe,
    input  predict_taken, pred_idx_if, flush, pc_rollback, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_if, branch_exe, pred_exe, idx_exe, is_zero, pc_exe, imm_exe,
    output predict_taken, pred_idx_if, flush, pc_rollback, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_predictor_sat_counter_table.sv
// Pattern history table: array of saturating counters with one combinational
// read port (IF) and one synchronous read-modify-write port (EXE).
module sat_counter_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int               DEPTH   = 1 << IDX_W;
  localparam ctr_t             CTR_MAX = ctr_t'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(INIT_CTR);

  logic [CTR_W-1:0] pht_q [DEPTH];
  logic [CTR_W-1:0] pht_d;
  ctr_t             cur_ctr;
  ctr_t             nxt_ctr;

  // No bypass: a same-cycle write to the read entry shows up one cycle later.
  assign rd_ctr_o = pht_q[rd_idx_i];

  always_comb begin
    cur_ctr = ctr_t'(pht_q[wr_idx_i]);
    nxt_ctr = wr_taken_i ? inc_sat(cur_ctr, CTR_MAX) : dec_sat(cur_ctr);
    pht_d   = CTR_W'(nxt_ctr);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= CTR_RST;
      end
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= pht_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor top: bimodal/gshare index hashing, global history,
// zero-latency mispredict flush with rollback PC, and saturating statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2,
  parameter int GSHARE   = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  branch_predictor_if.slave bp
);

  logic [IDX_W-1:0] ghr_q, ghr_d;
  pc_t              branch_cnt_q, branch_cnt_d;
  pc_t              mispred_cnt_q, mispred_cnt_d;
  logic [IDX_W-1:0] pred_idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             flush;
  logic             unused_bits;

  function automatic pc_t cnt_sat_inc(input pc_t cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + pc_t'(1) : cnt;
  endfunction

  assign pred_idx = (GSHARE != 0) ? (bp.pc_if[IDX_W+1:2] ^ ghr_q) : bp.pc_if[IDX_W+1:2];

  assign bp.pred_idx_if   = pred_idx;
  assign bp.predict_taken = rd_ctr[CTR_W-1];
  assign unused_bits      = ^{bp.pc_if, rd_ctr};

  assign flush          = bp.branch_exe & (bp.pred_exe != bp.is_zero);
  assign bp.flush       = flush;
  assign bp.pc_rollback = rollback_target(bp.branch_exe, bp.is_zero, bp.pc_exe, bp.imm_exe);
  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

  // idx_exe is the index carried down the pipeline, never re-hashed from pc_exe.
  sat_counter_table #(
    .IDX_W    (IDX_W),
    .CTR_W    (CTR_W),
    .INIT_CTR (INIT_CTR)
  ) u_pht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (pred_idx),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (bp.branch_exe),
    .wr_idx_i   (bp.idx_exe),
    .wr_taken_i (bp.is_zero)
  );

  always_comb begin
    ghr_d         = ghr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.branch_exe) begin
      // Truncating {ghr, outcome} shifts the outcome in; with IDX_W = 1 it is just the outcome.
      ghr_d         = IDX_W'({ghr_q, bp.is_zero});
      branch_cnt_d  = cnt_sat_inc(branch_cnt_q, 1'b1);
      mispred_cnt_d = cnt_sat_inc(mispred_cnt_q, flush);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance checked every cycle
// against an arithmetic model, plus directed vectors with hand-computed values.
module tb_branch_predictor;

  localparam int IW   = 4;
  localparam int NENT = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  branch_predictor_if #(.IDX_W(IW)) ifa ();
  branch_predictor_if #(.IDX_W(IW)) ifb ();

  branch_predictor #(.IDX_W(IW), .CTR_W(2), .INIT_CTR(2), .GSHARE(0)) dut_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bp    (ifa)
  );

  branch_predictor #(.IDX_W(IW), .CTR_W(2), .INIT_CTR(2), .GSHARE(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bp    (ifb)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state, index 0 = bimodal instance, 1 = gshare instance.
  int          pht_m  [2][NENT];
  int          ghr_m  [2];
  logic [31:0] bcnt_m [2];
  logic [31:0] mcnt_m [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < NENT; e++) pht_m[d][e] = 2;
      ghr_m[d]  = 0;
      bcnt_m[d] = 32'd0;
      mcnt_m[d] = 32'd0;
    end
  endtask

  function automatic int m_index(input logic [31:0] pc, input int ghr, input bit gs);
    int base;
    base = int'((pc / 4) % NENT);
    return gs ? (base ^ (ghr % NENT)) : base;
  endfunction

  function automatic logic [31:0] m_target(input bit taken, input logic [31:0] pc,
                                           input logic [31:0] imm);
    return taken ? pc + imm * 2 : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(negedge rst_n) model_reset();

  // Model update on every active edge out of reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        logic br, pr, tk;
        int   ie;
        br = (d == 0) ? ifa.branch_exe : ifb.branch_exe;
        pr = (d == 0) ? ifa.pred_exe   : ifb.pred_exe;
        tk = (d == 0) ? ifa.is_zero    : ifb.is_zero;
        ie = (d == 0) ? int'(ifa.idx_exe) : int'(ifb.idx_exe);
        if (br) begin
          if (tk) begin
            if (pht_m[d][ie] < 3) pht_m[d][ie] = pht_m[d][ie] + 1;
          end else if (pht_m[d][ie] > 0) begin
            pht_m[d][ie] = pht_m[d][ie] - 1;
          end
          ghr_m[d]  = (ghr_m[d] * 2 + (tk ? 1 : 0)) % NENT;
          bcnt_m[d] = m_sat(bcnt_m[d]);
          if (pr != tk) mcnt_m[d] = m_sat(mcnt_m[d]);
        end
      end
    end
  end

  // Compare every output of both instances mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [31:0] pc, pce, imm, a_rb, a_bc, a_mc;
      logic        br, pr, tk, a_tk, a_fl;
      logic [IW-1:0] a_idx;
      int          idx;
      if (d == 0) begin
        pc = ifa.pc_if; pce = ifa.pc_exe; imm = ifa.imm_exe;
        br = ifa.branch_exe; pr = ifa.pred_exe; tk = ifa.is_zero;
        a_tk = ifa.predict_taken; a_idx = ifa.pred_idx_if; a_fl = ifa.flush;
        a_rb = ifa.pc_rollback; a_bc = ifa.branch_cnt; a_mc = ifa.mispred_cnt;
      end else begin
        pc = ifb.pc_if; pce = ifb.pc_exe; imm = ifb.imm_exe;
        br = ifb.branch_exe; pr = ifb.pred_exe; tk = ifb.is_zero;
        a_tk = ifb.predict_taken; a_idx = ifb.pred_idx_if; a_fl = ifb.flush;
        a_rb = ifb.pc_rollback; a_bc = ifb.branch_cnt; a_mc = ifb.mispred_cnt;
      end
      idx = m_index(pc, ghr_m[d], d == 1);
      chk($sformatf("cmp%0d_idx", d), 32'(a_idx), idx);
      chk($sformatf("cmp%0d_pred", d), 32'(a_tk), (pht_m[d][idx] >= 2) ? 1 : 0);
      chk($sformatf("cmp%0d_flush", d), 32'(a_fl), (br && (pr != tk)) ? 1 : 0);
      chk($sformatf("cmp%0d_rollback", d), a_rb, m_target(br && tk, pce, imm));
      chk($sformatf("cmp%0d_bcnt", d), a_bc, bcnt_m[d]);
      chk($sformatf("cmp%0d_mcnt", d), a_mc, mcnt_m[d]);
    end
  end

  task automatic drive_a(input logic br, input logic pr, input logic [IW-1:0] ie,
                         input logic tk, input logic [31:0] pce, input logic [31:0] imm);
    ifa.branch_exe = br; ifa.pred_exe = pr; ifa.idx_exe = ie;
    ifa.is_zero = tk; ifa.pc_exe = pce; ifa.imm_exe = imm;
  endtask

  task automatic drive_b(input logic br, input logic pr, input logic [IW-1:0] ie,
                         input logic tk, input logic [31:0] pce, input logic [31:0] imm);
    ifb.branch_exe = br; ifb.pred_exe = pr; ifb.idx_exe = ie;
    ifb.is_zero = tk; ifb.pc_exe = pce; ifb.imm_exe = imm;
  endtask

  logic       pred_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       fl_v   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] ent_v  [5] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

  initial begin
    rst_n = 1'b0;
    ifa.pc_if = 32'h0;
    ifb.pc_if = 32'h0;
    drive_a(1'b0, 1'b0, '0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, '0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state seen from IF.
    ifa.pc_if = 32'h40;
    #1;
    chk("rst_pred", 32'(ifa.predict_taken), 32'd1);
    chk("rst_idx", 32'(ifa.pred_idx_if), 32'd0);
    chk("rst_bcnt", ifa.branch_cnt, 32'd0);
    chk("rst_mcnt", ifa.mispred_cnt, 32'd0);

    // Bimodal saturation towards not-taken on entry 0.
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, pred_v[k], 4'd0, 1'b0, 32'h40, 32'h0);
      #1;
      chk($sformatf("bim_flush%0d", k), 32'(ifa.flush), 32'(fl_v[k]));
      chk($sformatf("bim_rb%0d", k), ifa.pc_rollback, 32'h44);
      @(posedge clk); #1;
      chk($sformatf("bim_entry%0d", k), 32'(dut_a.u_pht.pht_q[0]), 32'(ent_v[k]));
      chk($sformatf("bim_pred%0d", k), 32'(ifa.predict_taken), 32'd0);
    end

    // Rollback targets.
    drive_a(1'b1, 1'b0, 4'd0, 1'b1, 32'h100, 32'h8);
    #1;
    chk("rb_taken_flush", 32'(ifa.flush), 32'd1);
    chk("rb_taken_pc", ifa.pc_rollback, 32'h110);
    @(posedge clk); #1;
    drive_a(1'b1, 1'b1, 4'd0, 1'b0, 32'h100, 32'h8);
    #1;
    chk("rb_nt_flush", 32'(ifa.flush), 32'd1);
    chk("rb_nt_pc", ifa.pc_rollback, 32'h104);
    @(posedge clk); #1;
    drive_a(1'b1, 1'b0, 4'd0, 1'b0, 32'hFFFF_FFFC, 32'h8);
    #1;
    chk("rb_wrap_flush", 32'(ifa.flush), 32'd0);
    chk("rb_wrap_pc", ifa.pc_rollback, 32'h0);
    @(posedge clk); #1;

    // Bring entry 0 to 1, then read and write it in the same cycle.
    drive_a(1'b1, 1'b1, 4'd0, 1'b1, 32'h40, 32'h0);
    @(posedge clk); #1;
    chk("rw_entry_pre", 32'(dut_a.u_pht.pht_q[0]), 32'd1);
    drive_a(1'b1, 1'b1, 4'd0, 1'b1, 32'h40, 32'h0);
    #1;
    chk("rw_same_cycle", 32'(ifa.predict_taken), 32'd0);
    @(posedge clk); #1;
    drive_a(1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    chk("rw_next_cycle", 32'(ifa.predict_taken), 32'd1);

    // Idle cycles leave statistics untouched: 10 branches, 4 mispredicts so far.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_bcnt", ifa.branch_cnt, 32'd10);
    chk("idle_mcnt", ifa.mispred_cnt, 32'd4);

    // Branch count saturation from a preloaded all-ones value.
    drive_a(1'b1, 1'b1, 4'd1, 1'b1, 32'h80, 32'h0);
    force dut_a.branch_cnt_q = 32'hFFFF_FFFF;
    bcnt_m[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut_a.branch_cnt_q;
    drive_a(1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sat_bcnt", ifa.branch_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("sat_bcnt_idle", ifa.branch_cnt, 32'hFFFF_FFFF);

    // Gshare history: taken, taken, not-taken gives GHR = 0b0110.
    ifb.pc_if = 32'h48;
    drive_b(1'b1, 1'b1, 4'd1, 1'b1, 32'h200, 32'h4);
    @(posedge clk); #1;
    drive_b(1'b1, 1'b1, 4'd2, 1'b1, 32'h204, 32'h4);
    @(posedge clk); #1;
    drive_b(1'b1, 1'b1, 4'd3, 1'b0, 32'h208, 32'h4);
    @(posedge clk); #1;
    drive_b(1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("gs_idx", 32'(ifb.pred_idx_if), 32'd4);
    chk("gs_pred", 32'(ifb.predict_taken), 32'd1);
    chk("gs_entry3", 32'(dut_b.u_pht.pht_q[3]), 32'd1);

    // Asynchronous reset mid-cycle takes effect immediately.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_gs_idx", 32'(ifb.pred_idx_if), 32'd2);
    chk("arst_entry3", 32'(dut_b.u_pht.pht_q[3]), 32'd2);
    chk("arst_entry1", 32'(dut_b.u_pht.pht_q[1]), 32'd2);
    chk("arst_bcnt_a", ifa.branch_cnt, 32'd0);
    chk("arst_bcnt_b", ifb.branch_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idx", 32'(ifb.pred_idx_if), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
